// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader placed in front of the single-cycle core's program memory
// and PC. A byte stream arrives over a valid/ready handshake and is framed as:
//   word count N (16 bits, low byte first), then 4*N instruction bytes with the
//   least-significant byte of each word first.
// Words are assembled and written to program memory at consecutive word-aligned
// byte addresses starting at 0. The core is held in reset until the whole image
// has been written. A bad word count or a stalled stream aborts the load.
//
// Ports:
//   clk             system clock, all state changes on the rising edge
//   reset           asynchronous, active-low reset
//   Start_i         one-cycle pulse starting a load (honoured in IDLE/DONE/ERROR)
//   Byte_Data_i     incoming stream byte
//   Byte_Valid_i    Byte_Data_i is valid
//   Byte_Ready_o    loader accepts a byte this cycle
//   Prog_Write_o    one-cycle program memory write strobe
//   Prog_Address_o  byte address of the word being written (word-aligned)
//   Prog_Data_o     instruction word being written
//   Core_Reset_o    active-low core reset; 1 only once the image is complete
//   Done_o          image loaded successfully
//   Error_o         load aborted (bad length or timeout)
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int PROGRAM_MEMORY_DEPTH = 64,
  parameter int TIMEOUT_CYCLES       = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_i,
  input  logic [7:0]  Byte_Data_i,
  input  logic        Byte_Valid_i,
  output logic        Byte_Ready_o,
  output logic        Prog_Write_o,
  output logic [31:0] Prog_Address_o,
  output logic [31:0] Prog_Data_o,
  output logic        Core_Reset_o,
  output logic        Done_o,
  output logic        Error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_LEN_CHK,  // one cycle to validate the full 16-bit word count
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W      = 17'(PROGRAM_MEMORY_DEPTH);
  // The transition fires on the idle cycle that brings the gap count up to
  // TIMEOUT_CYCLES, so ERROR is reached exactly TIMEOUT_CYCLES cycles after
  // the last accepted byte.
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state, next_state;

  logic [15:0] word_count;   // N from the frame header
  logic [15:0] word_idx;     // index of the next word to be written
  logic [1:0]  byte_idx;     // position of the next data byte within the word
  logic [31:0] data_reg;     // word under assembly
  logic [23:0] gap_cnt;      // idle cycles since the last accepted byte

  logic        ready_q;
  logic        prog_write_q;
  logic [31:0] prog_address_q;
  logic [31:0] prog_data_q;
  logic        core_reset_q;
  logic        done_q;
  logic        error_q;

  logic        byte_accept;
  logic        counting;
  logic        timeout_hit;
  logic        len_bad;
  logic        load_start;
  logic [31:0] word_next;

  // ---------------------------------------------------------------------------
  // Combinational decode and next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    byte_accept = Byte_Valid_i && ready_q;
    counting    = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
    timeout_hit = counting && !byte_accept && (gap_cnt == TIMEOUT_LAST);
    len_bad     = (word_count == 16'd0) || ({1'b0, word_count} > DEPTH_W);
    load_start  = 1'b0;

    // Current word with the incoming byte merged into its lane; becomes the
    // data register on a DATA accept and the written word on the 4th byte.
    word_next                      = data_reg;
    word_next[{byte_idx, 3'b000} +: 8] = Byte_Data_i;

    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start_i) begin
          next_state = S_LEN_LO;
          load_start = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (timeout_hit)      next_state = S_ERROR;
        else if (byte_accept) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (timeout_hit)      next_state = S_ERROR;
        else if (byte_accept) next_state = S_LEN_CHK;
      end
      S_LEN_CHK: begin
        next_state = len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (timeout_hit)                              next_state = S_ERROR;
        else if (byte_accept && (byte_idx == 2'd3))   next_state = S_WRITE;
      end
      S_WRITE: begin
        next_state = ((word_idx + 16'd1) == word_count) ? S_DONE : S_DATA;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Datapath: header, assembly, indices and gap counter
  // ---------------------------------------------------------------------------
  // NOTE: every register here is small control/data state and is cleared by
  // the async reset; there is no storage array that would need to be left
  // unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_count <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      data_reg   <= '0;
      gap_cnt    <= '0;
    end else begin
      // Gap counter: fresh on a new load and on every accepted byte, frozen
      // in LEN_CHK and WRITE.
      if (load_start || byte_accept) gap_cnt <= '0;
      else if (counting)             gap_cnt <= gap_cnt + 24'd1;

      if (load_start) begin
        word_count <= '0;
        word_idx   <= '0;
        byte_idx   <= '0;
        data_reg   <= '0;
      end

      if (byte_accept) begin
        unique case (state)
          S_LEN_LO: word_count[7:0]  <= Byte_Data_i;
          S_LEN_HI: word_count[15:8] <= Byte_Data_i;
          S_DATA: begin
            data_reg <= word_next;
            byte_idx <= byte_idx + 2'd1;
          end
          default: ;
        endcase
      end

      if (state == S_WRITE) begin
        word_idx <= word_idx + 16'd1;
        byte_idx <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from next_state so each one changes only on a
  // clock edge and is valid for the whole cycle of the state it belongs to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q        <= 1'b0;
      prog_write_q   <= 1'b0;
      prog_address_q <= '0;
      prog_data_q    <= '0;
      core_reset_q   <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      ready_q      <= (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                      (next_state == S_DATA);
      prog_write_q <= (next_state == S_WRITE);
      core_reset_q <= (next_state == S_DONE);
      done_q       <= (next_state == S_DONE);
      error_q      <= (next_state == S_ERROR);

      // Address and data are captured only when a write is launched and hold
      // their last values otherwise.
      if (next_state == S_WRITE) begin
        prog_address_q <= {14'd0, word_idx, 2'b00};
        prog_data_q    <= word_next;
      end
    end
  end

  assign Byte_Ready_o   = ready_q;
  assign Prog_Write_o   = prog_write_q;
  assign Prog_Address_o = prog_address_q;
  assign Prog_Data_o    = prog_data_q;
  assign Core_Reset_o   = core_reset_q;
  assign Done_o         = done_q;
  assign Error_o        = error_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader sitting directly upstream of the single-cycle core's program memory and PC.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them sequentially into program memory.
- Holds the core in reset until a complete, valid image has been written, then releases it so the PC starts fetching at address 0.

Parameters:
PROGRAM_MEMORY_DEPTH, 64, program memory size in 32-bit words; maximum loadable word count.
TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while a load is in progress; valid range 1..2^24-1.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
Start_i  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR
Byte_Data_i  input  8  incoming stream byte
Byte_Valid_i  input  1  Byte_Data_i is valid
Byte_Ready_o  output  1  loader can accept a byte this cycle
Prog_Write_o  output  1  one-cycle write strobe to program memory
Prog_Address_o  output  32  byte address of the word being written; always word-aligned
Prog_Data_o  output  32  instruction word being written
Core_Reset_o  output  1  active-low reset to the core; 0 holds the core in reset
Done_o  output  1  image loaded successfully
Error_o  output  1  load aborted

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE;
  - all counters and the data register cleared;
  - Byte_Ready_o=0, Prog_Write_o=0, Prog_Address_o=0, Prog_Data_o=0;
  - Core_Reset_o=0, Done_o=0, Error_o=0.
- Reset mid-load discards all progress; no partial-write recovery.
- Byte accept: Byte_Valid_i=1 and Byte_Ready_o=1 on the same rising edge. Byte_Ready_o=1 only in LEN_LO, LEN_HI and DATA. A byte presented while Byte_Ready_o=0 is not consumed and must be held by the source.
- Frame format: word count N (16 bits, low byte first), then 4*N instruction bytes, each word's least-significant byte first.
- State machine:
  - IDLE: Start_i=1 -> LEN_LO.
  - LEN_LO: accept byte -> N[7:0], go to LEN_HI.
  - LEN_HI: accept byte -> N[15:8].
    - Next-cycle check uses the full 16-bit N: if N=0 or N>PROGRAM_MEMORY_DEPTH -> ERROR.
    - Otherwise -> DATA with word index 0 and byte index 0.
  - DATA: each accepted byte is placed into bits [8*k+7:8*k] of the data register, where k is the byte index (0..3); the byte index then increments. After the 4th byte (k=3) is accepted -> WRITE.
  - WRITE: exactly one cycle.
    - Prog_Write_o=1, Prog_Address_o=word_index*4, Prog_Data_o=assembled word.
    - word_index increments; byte index clears.
    - If the incremented word_index equals N -> DONE, else -> DATA.
  - DONE: Core_Reset_o=1, Done_o=1. Start_i=1 -> LEN_LO, with Core_Reset_o and Done_o returning to 0 on that same edge.
  - ERROR: Error_o=1, Core_Reset_o=0. Start_i=1 -> LEN_LO, clearing Error_o.
- Start_i in LEN_LO, LEN_HI, DATA or WRITE is ignored.
- Prog_Address_o and Prog_Data_o hold their last written values outside WRITE. Prog_Write_o is 0 outside WRITE.
- Timeout:
  - A gap counter clears on every accepted byte and on entry to LEN_LO.
  - It increments every cycle in LEN_LO, LEN_HI and DATA when no byte is accepted.
  - On reaching TIMEOUT_CYCLES -> ERROR; no further program memory writes occur.
  - The counter is frozen in WRITE.
- Throughput: 4 byte-accept cycles plus 1 WRITE cycle per word; at most 1 byte per cycle.
- Core_Reset_o changes only on clock edges (no glitches) and is 0 in every state except DONE.
- A later load overwrites memory only up to word N-1. Words beyond N keep their old contents; this is not an error.

Test Plan:
- Reset, Start_i pulse, stream 02 00 13 05 50 00 B3 05 B5 00 with Byte_Valid_i held 1 -> exactly two writes:
  - addr 0x0, data 0x00500513;
  - addr 0x4, data 0x00B505B3;
  - then Done_o=1, Core_Reset_o=1.
- Stream length 00 00 -> ERROR, Error_o=1, Core_Reset_o=0, no Prog_Write_o pulse. Repeat with 41 00 (65, DEPTH=64) -> same; 40 00 (64) is accepted.
- Byte_Valid_i held 1 with a new byte present during the WRITE cycle -> Byte_Ready_o=0, byte not consumed, accepted on the following cycle unchanged.
- TIMEOUT_CYCLES=16: send length 01 00 and 2 data bytes, then idle -> ERROR exactly 16 cycles after the last accept, no write. A subsequent Start_i and a full valid frame -> DONE.
- Assert reset after 6 data bytes of a 2-word load -> all outputs return to reset values immediately (asynchronously), no second write. Start_i and a fresh frame -> correct load from word 0.
- After DONE, pulse Start_i -> Core_Reset_o drops to 0 on the same edge. A 1-word reload writes address 0 only.
